ram_lfsr_bist_ctrl: RTL and testbench



---
 rtl/ram_lfsr_bist_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ram_lfsr_bist_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lfsr_bist_ctrl.sv
// LFSR pattern self-test sequencer for one port of a registered-address RAM:
// writes a pseudo-random pattern to every word, reads it back and counts mismatches.
module ram_lfsr_bist_ctrl #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'hA3000000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int                PIPE_N    = RD_LAT + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] exp;
    logic [ADDR_W-1:0] addr;
  } pipe_t;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_POLY : '0);
  endfunction

  state_e            state_q, state_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [DATA_W-1:0] first_err_data_q, first_err_data_d;
  pipe_t             pipe_q [PIPE_N];
  pipe_t             pipe_d [PIPE_N];

  logic              start_ok;
  logic              at_last;
  logic              pipe_empty;
  logic [DATA_W-1:0] seed_eff;
  pipe_t             last_stage;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  assign seed_eff   = (seed == '0) ? DATA_W'(1) : seed;
  assign start_ok   = start && (state_q == IDLE || state_q == DONE);
  assign at_last    = (ram_addr_q == LAST_ADDR);
  assign last_stage = pipe_q[PIPE_N-1];

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < PIPE_N; i++) begin
      if (pipe_q[i].vld) pipe_empty = 1'b0;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_ok)   state_d = WRITE;
      WRITE:      if (at_last)    state_d = READ;
      READ:       if (at_last)    state_d = DRAIN;
      DRAIN:      if (pipe_empty) state_d = DONE;
      default:                    state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, LFSR and compare pipeline.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    seed_d           = seed_q;
    lfsr_d           = lfsr_q;
    ram_addr_d       = ram_addr_q;
    ram_we_d         = ram_we_q;
    ram_din_d        = ram_din_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    first_err_data_d = first_err_data_q;
    pipe_d[0]        = '0;
    for (int i = 1; i < PIPE_N; i++) pipe_d[i] = pipe_q[i-1];

    // The oldest pipeline entry lines up with the RAM data for its address.
    if (last_stage.vld && (ram_dout != last_stage.exp)) begin
      err_count_d = err_count_q + 1'b1;
      if (err_count_q == '0) begin
        first_err_addr_d = last_stage.addr;
        first_err_data_d = ram_dout;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          seed_d           = seed_eff;
          lfsr_d           = seed_eff;
          ram_addr_d       = '0;
          ram_we_d         = 1'b1;
          ram_din_d        = seed_eff;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          first_err_data_d = '0;
        end
      end
      WRITE: begin
        if (at_last) begin
          ram_we_d   = 1'b0;
          ram_addr_d = '0;
          lfsr_d     = seed_q;
          pipe_d[0]  = '{vld: 1'b1, exp: seed_q, addr: '0};
        end else begin
          ram_addr_d = ram_addr_q + 1'b1;
          lfsr_d     = lfsr_next(lfsr_q);
          ram_din_d  = lfsr_next(lfsr_q);
        end
      end
      READ: begin
        if (!at_last) begin
          ram_addr_d = ram_addr_q + 1'b1;
          lfsr_d     = lfsr_next(lfsr_q);
          pipe_d[0]  = '{vld: 1'b1, exp: lfsr_next(lfsr_q), addr: ram_addr_q + 1'b1};
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_count_q == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_q           <= '0;
      lfsr_q           <= '0;
      ram_addr_q       <= '0;
      ram_we_q         <= 1'b0;
      ram_din_q        <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      // NOTE: the compare pipeline is a few flops, not a RAM, so it is reset:
      // a stale valid bit after reset would count a bogus mismatch.
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
    end else begin
      seed_q           <= seed_d;
      lfsr_q           <= lfsr_d;
      ram_addr_q       <= ram_addr_d;
      ram_we_q         <= ram_we_d;
      ram_din_q        <= ram_din_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_data_q <= first_err_data_d;
      for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign ram_addr       = ram_addr_q;
  assign ram_we         = ram_we_q;
  assign ram_din        = ram_din_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_ram_lfsr_bist_ctrl.sv
// Bench for ram_lfsr_bist_ctrl: behavioural RAM with fault injection, a
// timeline model of the expected outputs, and a per-cycle compare process.
module tb_ram_lfsr_bist_ctrl;

  localparam int          ADDR_W  = 10;
  localparam int          DATA_W  = 32;
  localparam int          DEPTH   = 1024;
  localparam int          RD_LAT  = 1;
  localparam logic [31:0] POLY    = 32'hA3000000;
  localparam int          RUN_LEN = 2 * DEPTH + RD_LAT + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] seed = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy, done, pass;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  ram_lfsr_bist_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .LFSR_POLY(POLY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Registered-address RAM with optional read faults (1: bit0 flip at 0x155, 2: bit31 stuck at 0).
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_r = '0;
  logic [DATA_W-1:0] wsum = '0;
  int                fault_mode = 0;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wsum          <= wsum + ram_din;
    end
    addr_r <= ram_addr;
  end

  always_comb begin
    ram_dout = mem[addr_r];
    if (fault_mode == 1 && addr_r == 10'h155) ram_dout[0] = ~ram_dout[0];
    if (fault_mode == 2) ram_dout[31] = 1'b0;
  end

  // Reference model: the whole run is a fixed timeline measured from the start edge.
  logic [31:0] pat [DEPTH];
  logic [31:0] bad [DEPTH];
  bit          faulty [DEPTH];
  bit          m_run = 1'b0;
  int          m_t = 0;
  int          m_err = 0;
  int          m_a;
  logic [9:0]  m_fea = '0;
  logic [31:0] m_fed = '0;

  task automatic load_pattern(input logic [31:0] s, input int mode);
    logic [31:0] l;
    l = (s == 0) ? 32'h1 : s;
    for (int a = 0; a < DEPTH; a++) begin
      pat[a] = l;
      bad[a] = l;
      if (mode == 1 && a == 'h155) bad[a] = l ^ 32'h1;
      if (mode == 2) bad[a] = l & 32'h7FFF_FFFF;
      faulty[a] = (bad[a] != pat[a]);
      l = (l >> 1) ^ (l[0] ? POLY : 32'h0);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0; m_err = 0; m_fea = '0; m_fed = '0;
    end else if (start && (!m_run || m_t >= RUN_LEN)) begin
      load_pattern(seed, fault_mode);
      m_run = 1'b1; m_t = 0; m_err = 0; m_fea = '0; m_fed = '0;
    end else if (m_run && m_t < RUN_LEN) begin
      m_t++;
      m_a = m_t - (DEPTH + RD_LAT + 1);
      if (m_a >= 0 && m_a < DEPTH && faulty[m_a]) begin
        if (m_err == 0) begin
          m_fea = m_a[9:0];
          m_fed = bad[m_a];
        end
        m_err++;
      end
    end
  end

  always @(negedge clk) begin
    logic        e_we, e_busy, e_done, e_pass;
    logic [9:0]  e_addr;
    logic [31:0] e_din;
    logic [10:0] e_err;
    if (cmp_en) begin
      e_we = 0; e_busy = 0; e_done = 0; e_pass = 0; e_addr = '0; e_din = '0; e_err = '0;
      if (m_run) begin
        e_we   = (m_t < DEPTH);
        e_addr = (m_t < DEPTH) ? 10'(m_t) : (m_t < 2 * DEPTH) ? 10'(m_t - DEPTH) : 10'(DEPTH - 1);
        e_din  = (m_t < DEPTH) ? pat[m_t] : pat[DEPTH-1];
        e_busy = (m_t < RUN_LEN);
        e_done = !e_busy;
        e_pass = e_done && (m_err == 0);
        e_err  = 11'(m_err);
      end
      check($sformatf("cycle_t%0d", m_t),
            {ram_we, busy, done, pass, ram_addr, ram_din, err_count, first_err_addr, first_err_data},
            {e_we, e_busy, e_done, e_pass, e_addr, e_din, e_err,
             m_run ? m_fea : 10'h0, m_run ? m_fed : 32'h0});
    end
  end

  // One full test; optionally pokes start mid-run. Returns a few early samples.
  task automatic run_test(input logic [31:0] s, input int mode, input int poke_at,
                          output int cycles, output logic [31:0] din0, output logic [31:0] din1,
                          output logic done0, output logic [10:0] err0);
    @(negedge clk);
    fault_mode = mode;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seed  = $urandom;
    din0  = ram_din;
    done0 = done;
    err0  = err_count;
    din1  = '0;
    cycles = 0;
    while (!done && cycles < 3000) begin
      if (cycles == poke_at) begin
        start = 1'b1;
        seed  = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (cycles == 1) din1 = ram_din;
    end
    check("done_timing", 128'(cycles), 128'(RUN_LEN));
  endtask

  int          cyc;
  logic [31:0] d0, d1;
  logic        dn0;
  logic [10:0] e0;
  logic [31:0] sum_a, sum_b;
  int          n31;
  bit          found;

  initial begin
    // Reset for 3 cycles, then idle.
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_quiet", {ram_we, busy, done, pass, err_count}, 15'h0);

    // Clean pass.
    run_test(32'hACE1, 0, -1, cyc, d0, d1, dn0, e0);
    check("first_write_din", d0, 32'hACE1);
    check("second_write_din", d1, 32'hA3005670);
    check("clean_result", {pass, err_count}, {1'b1, 11'd0});

    // Single flipped bit at 0x155.
    run_test(32'hACE1, 1, -1, cyc, d0, d1, dn0, e0);
    check("single_err", {pass, err_count, first_err_addr}, {1'b0, 11'd1, 10'h155});
    check("single_data", first_err_data, pat['h155] ^ 32'h1);

    // Bit 31 stuck at 0.
    run_test(32'hACE1, 2, -1, cyc, d0, d1, dn0, e0);
    n31 = 0;
    for (int a = 0; a < DEPTH; a++) n31 += int'(pat[a][31]);
    check("stuck_count", err_count, 11'(n31));
    check("stuck_first", {first_err_addr, first_err_data}, {10'h001, 32'h23005670});

    // Restart from DONE with a fresh seed: results clear at the start edge.
    run_test(32'h1234, 0, -1, cyc, d0, d1, dn0, e0);
    check("restart_clear", {dn0, e0}, 12'h0);
    check("restart_pass", {pass, err_count}, {1'b1, 11'd0});

    // Zero seed behaves like seed 1.
    sum_a = wsum;
    run_test(32'h0, 0, -1, cyc, d0, d1, dn0, e0);
    check("seed0_first_din", d0, 32'h1);
    sum_b = wsum - sum_a;
    sum_a = wsum;
    run_test(32'h1, 0, -1, cyc, d0, d1, dn0, e0);
    check("seed0_eq_seed1", sum_b, wsum - sum_a);

    // Start pulse during WRITE is ignored.
    run_test($urandom, 0, 700, cyc, d0, d1, dn0, e0);
    check("poke_pass", pass, 1'b1);

    // Randomised seeds and fault modes.
    for (int r = 0; r < 2; r++) begin
      run_test($urandom, int'($urandom_range(0, 2)), -1, cyc, d0, d1, dn0, e0);
      check("rand_pass", pass, 1'(m_err == 0));
    end

    // Reset in the middle of WRITE.
    @(negedge clk);
    fault_mode = 0;
    seed  = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      if (ram_addr == 10'd500 && ram_we) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_addr_500", found, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_write", {ram_we, busy}, 2'b00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
